// File: rtl/pool_ctrl.sv
// 2x2 max-pool sequencing controller: walks a MAP_W x MAP_H feature map, steers the line FIFO, flags full windows.
// Optional POOL_CTRL_DROP_CHK_EN adds a sticky flag for pixels offered while the controller is not accepting.
module pool_ctrl #(
   parameter int MAP_W = 28,
   parameter int MAP_H = 28
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       fifo_wrreq,
   output logic       fifo_rdreq,
   output logic       fifo_clr,
   output logic       win_valid,
   output logic [5:0] col_idx,
   output logic [5:0] row_idx,
   output logic       busy,
   output logic       done,
   output logic       err_drop
);

   typedef enum logic [1:0] {S_IDLE, S_EVEN, S_ODD, S_DONE} state_t;

   localparam logic [5:0] LAST_COL = 6'(MAP_W - 1);
   localparam logic [5:0] LAST_ROW = 6'(MAP_H - 1);

   state_t     r_state, w_next;
   logic [5:0] r_col, r_row;
   logic       r_win;
   logic       w_row_st, w_accept, w_start_ok, w_last_col, w_last_row;

   assign w_last_col = (r_col == LAST_COL);
   assign w_last_row = (r_row == LAST_ROW);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_EVEN;
         S_EVEN:  if (w_accept && w_last_col) w_next = w_last_row ? S_DONE : S_ODD;
         S_ODD:   if (w_accept && w_last_col) w_next = w_last_row ? S_DONE : S_EVEN;
         default: w_next = S_IDLE;
      endcase
   end

   // Every output is forced to its idle value while rst is high, so reset wins over start/in_valid.
   always_comb begin
      w_row_st   = (r_state == S_EVEN) || (r_state == S_ODD);
      w_start_ok = (r_state == S_IDLE) && start;
      in_ready   = w_row_st && !rst;
      w_accept   = in_valid && in_ready;
      fifo_wrreq = w_accept && (r_state == S_EVEN);
      fifo_rdreq = w_accept && (r_state == S_ODD);
      fifo_clr   = rst || w_start_ok;
      busy       = (r_state != S_IDLE) && !rst;
      done       = (r_state == S_DONE) && !rst;
      win_valid  = r_win && !rst;
   end

   always_ff @(posedge clk) begin
      if (rst || w_start_ok) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_accept) begin
         if (w_last_col) begin
            r_col <= '0;
            r_row <= w_last_row ? 6'd0 : r_row + 6'd1;
         end else begin
            r_col <= r_col + 6'd1;
         end
      end
   end

   // A window closes on the odd-column pixel of an odd row, which is the bottom-right of the 2x2.
   always_ff @(posedge clk) begin
      if (rst) r_win <= 1'b0;
      else     r_win <= w_accept && (r_state == S_ODD) && r_col[0];
   end

   assign col_idx = r_col;
   assign row_idx = r_row;

`ifdef POOL_CTRL_DROP_CHK_EN
   logic r_err;
   always_ff @(posedge clk) begin
      if (rst || w_start_ok)         r_err <= 1'b0;
      else if (in_valid && !in_ready) r_err <= 1'b1;
   end
   assign err_drop = r_err && !rst;
`else
   assign err_drop = 1'b0;
`endif

endmodule

// File: tb/tb_pool_ctrl.sv
// Scoreboarded bench for pool_ctrl at 28x28: window/done timing via queues, FIFO strobes and indices per cycle.
module tb_pool_ctrl;
   localparam int W = 28, H = 28;
   localparam int S_IDLE = 0, S_EVEN = 1, S_ODD = 2, S_DONE = 3;
`ifdef POOL_CTRL_DROP_CHK_EN
   localparam int DROP_EN = 1;
`else
   localparam int DROP_EN = 0;
`endif

   logic clk = 0, rst = 1, start = 0, in_valid = 0;
   logic in_ready, fifo_wrreq, fifo_rdreq, fifo_clr, win_valid, busy, done, err_drop;
   logic [5:0] col_idx, row_idx;

   pool_ctrl #(.MAP_W(W), .MAP_H(H)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .fifo_wrreq(fifo_wrreq), .fifo_rdreq(fifo_rdreq), .fifo_clr(fifo_clr), .win_valid(win_valid),
      .col_idx(col_idx), .row_idx(row_idx), .busy(busy), .done(done), .err_drop(err_drop));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vecs = 0, errs = 0;
   int ms = S_IDLE, mcol = 0, mrow = 0, merr = 0;
   int wins = 0, nwr = 0, nrd = 0;
   int winq[$], doneq[$];

   task automatic chk(input string name, input int act, input int exp);
      vecs++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every win_valid/done pulse must match the cycle the model predicted.
   always @(negedge clk) begin
      if (win_valid) begin
         wins++;
         if (winq.size() == 0) chk("win_unexpected", cyc, -1);
         else chk("win_cycle", cyc, winq.pop_front());
      end
      while (winq.size() > 0 && winq[0] < cyc) chk("win_missed", -1, winq.pop_front());
      if (done) begin
         if (doneq.size() == 0) chk("done_unexpected", cyc, -1);
         else chk("done_cycle", cyc, doneq.pop_front());
      end
      while (doneq.size() > 0 && doneq[0] < cyc) chk("done_missed", -1, doneq.pop_front());
   end

   task automatic drive(input logic v, input logic s);
      bit rowst, acc;
      int k;
      in_valid = v;
      start    = s;
      @(negedge clk);
      k     = cyc;
      rowst = (ms == S_EVEN) || (ms == S_ODD);
      acc   = v && rowst;
      chk("in_ready", in_ready, rowst);
      chk("busy", busy, ms != S_IDLE);
      chk("fifo_wrreq", fifo_wrreq, acc && ms == S_EVEN);
      chk("fifo_rdreq", fifo_rdreq, acc && ms == S_ODD);
      chk("fifo_clr", fifo_clr, ms == S_IDLE && s);
      chk("col_idx", col_idx, mcol);
      chk("row_idx", row_idx, mrow);
      chk("err_drop", err_drop, merr);
      if (fifo_wrreq) nwr++;
      if (fifo_rdreq) nrd++;
      if (ms == S_IDLE && s) merr = 0;
      else if (v && !rowst) merr = DROP_EN;
      if (ms == S_IDLE) begin
         if (s) begin ms = S_EVEN; mcol = 0; mrow = 0; end
      end else if (ms == S_DONE) begin
         ms = S_IDLE;
      end else if (acc) begin
         if (ms == S_ODD && (mcol % 2) == 1) winq.push_back(k + 1);
         if (mcol == W - 1) begin
            mcol = 0;
            if (mrow == H - 1) begin
               mrow = 0; ms = S_DONE; doneq.push_back(k + 1);
            end else begin
               mrow++; ms = (ms == S_EVEN) ? S_ODD : S_EVEN;
            end
         end else mcol++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic v, input logic s);
      rst = 1; in_valid = v; start = s;
      @(negedge clk);
      chk("rst_fifo_clr", fifo_clr, 1);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_wrreq", fifo_wrreq | fifo_rdreq, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_win", win_valid, 0);
      chk("rst_err", err_drop, 0);
      winq.delete(); doneq.delete();
      @(posedge clk);
      #1;
      rst = 0; in_valid = 0; start = 0;
      ms = S_IDLE; mcol = 0; mrow = 0; merr = 0;
   endtask

   // mode 0: back-to-back pixels, 1: 50% random valid, 2: random plus start pulses at row 5
   task automatic run_frame(input int mode);
      int n = 0;
      logic v, s;
      wins = 0; nwr = 0; nrd = 0;
      drive(0, 1);
      while (ms != S_DONE && n < 5000) begin
         v = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         s = (mode == 2) && (mrow == 5) && (mcol == 3);
         drive(v, s);
         n++;
      end
      if (n >= 5000) chk("frame_timeout", n, 0);
      drive(0, 0);
      chk("wins_per_frame", wins, (W / 2) * (H / 2));
      chk("fifo_wr_count", nwr, W * H / 2);
      chk("fifo_rd_count", nrd, W * H / 2);
   endtask

   initial begin
      do_reset(1, 1);
      drive(0, 0);
      drive(0, 0);
      run_frame(0);
      drive(0, 0);
      run_frame(2);
      run_frame(1);
      drive(0, 0);
      // Abandon a frame at row 3 col 10 with start and in_valid also high.
      drive(0, 1);
      while (ms != S_DONE && !(mrow == 3 && mcol == 10)) drive(1, 0);
      do_reset(1, 1);
      drive(0, 0);
      drive(0, 0);
      run_frame(0);
      // Pixel offered while idle.
      drive(1, 0);
      drive(0, 0);
      drive(0, 0);
      run_frame(1);
      drive(0, 0);
      repeat (3) @(negedge clk);
      chk("winq_empty", winq.size(), 0);
      chk("doneq_empty", doneq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
